regfile_wb_arbiter: RTL and testbench
=====================================

// Module: regfile_wb_arbiter
// PURPOSE
//  Shares the register file's single write port (rd/writedata/reg_write) between two writeback requesters:
//  A = ALU result path, B = load-return path. Valid/ready handshake per requester; round-robin grant.
//  Registered output drives the register file one cycle after acceptance; register file commits on negedge clk.
//  Also exports a pending-destination mask for the hazard detection unit and a contention counter.
// PARAMETERS
//  XLEN    64  data width of writeback value
//  AW      5   register index width (2**AW registers; index 0 is hard-wired zero)
//  CNT_W   16  width of contention counter (saturating)
// PORTS
//  clk           in   1      system clock, all state on posedge
//  reset         in   1      synchronous, active-high
//  a_valid       in   1      requester A has a write
//  a_rd          in   AW     A destination index
//  a_data        in   XLEN   A write value
//  a_ready       out  1      A accepted this cycle (valid&ready at posedge)
//  b_valid       in   1      requester B has a write
//  b_rd          in   AW     B destination index
//  b_data        in   XLEN   B write value
//  b_ready       out  1      B accepted this cycle
//  rf_rd         out  AW     to register file rd
//  rf_writedata  out  XLEN   to register file writedata
//  rf_reg_write  out  1      to register file reg_write
//  pending_mask  out  2**AW  bit i set: a write to reg i is waiting or in the output stage
//  conflict_cnt  out  CNT_W  cycles where both requesters were valid
// BEHAVIOUR
//  - Reset (sync, sampled on posedge): rf_reg_write=0, rf_rd=0, rf_writedata=0, pointer=PREF_A,
//    conflict_cnt=0. a_ready=b_ready=0 while reset is high. Write held in output stage is discarded.
//  - a_ready/b_ready are combinational from valids, rd values and pointer. At most one is high per cycle.
//    Neither is high when both valids are low.
//  - Grant rules:
//    - Only one valid: grant it.
//    - Both valid, rd differ or either rd==0: grant the pointer's preference.
//    - Both valid, same nonzero rd: grant B first (older instruction). Pointer unchanged.
//      A is granted next cycle, so A's value is the final one.
//  - Pointer FSM: states PREF_A, PREF_B.
//    - A granted under round-robin -> PREF_B. B granted under round-robin -> PREF_A.
//    - Otherwise hold.
//  - Latency: accepted at posedge N -> rf_* hold that write for exactly cycle N..N+1. Register file commits at negedge in that cycle.
//    rf_reg_write=0 in any cycle with no acceptance at the preceding edge.
//  - rd==0: accepted normally (ready asserted), but rf_reg_write stays 0 and rf_rd/rf_writedata are don't-care-free (0).
//  - Requester contract: valid, rd and data are held stable until ready. The block does not buffer unaccepted requests.
//  - pending_mask = (a_valid&~a_ready ? 1<<a_rd : 0) | (b_valid&~b_ready ? 1<<b_rd : 0)
//    | (rf_reg_write ? 1<<rf_rd : 0). Bit 0 is always 0.
//  - conflict_cnt increments when a_valid&b_valid, saturates at all-ones, and holds under no other condition.
//  - Reset asserted mid-stream: output write dropped, requests not accepted. Requesters re-present after reset.
// STRUCTURE
//  - Shared package rf_pkg: XLEN, AW, NREG=2**AW, typedef rf_idx_t, typedef rf_wreq_t {rd, data},
//    enum arb_state_e {PREF_A, PREF_B}.
//  - Sub-module rr_arb2: 2-way round-robin grant with pointer FSM and a force_b input (same-rd rule).
//  - Top holds output register, pending mask and counter.
// TESTING
//  - Reset: hold reset 3 cycles with a_valid=1, a_rd=5 -> a_ready=0, rf_reg_write=0, conflict_cnt=0.
//  - Single: A writes rd=3, data=0x1234 -> a_ready=1 that cycle. Next cycle rf_rd=3, writedata=0x1234, reg_write=1, for one cycle only.
//  - Round-robin: both valid every cycle, rd A=1, B=2, 4 cycles -> grants A,B,A,B; conflict_cnt=4.
//  - Same rd: A(rd=7,0xAA) and B(rd=7,0xBB) valid from PREF_A -> B first, then A.
//    Register 7 ends 0xAA; pointer still PREF_A after the B grant.
//  - x0: B rd=0, data=0xFF -> b_ready=1, rf_reg_write stays 0, pending_mask bit0=0.
//  - Reset mid-op: accept A rd=4, then assert reset at the next edge -> rf_reg_write=0, reg 4 unchanged.
//    Saturation: force counter to all-ones -1, keep conflict 3 cycles -> stays 0xFFFF.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared types for the register-file writeback arbiter.
//   XLEN        : width of a writeback value
//   AW          : register index width; NREG = 2**AW registers, index 0 hard-wired zero
//   rf_idx_t    : register index
//   rf_wreq_t   : one writeback request {rd, data}
//   arb_state_e : round-robin pointer (which requester wins the next contended cycle)
package rf_pkg;

  localparam int unsigned XLEN = 64;
  localparam int unsigned AW   = 5;
  localparam int unsigned NREG = 2 ** AW;

  typedef logic [AW-1:0] rf_idx_t;

  typedef struct packed {
    rf_idx_t         rd;
    logic [XLEN-1:0] data;
  } rf_wreq_t;

  typedef enum logic [0:0] {
    PREF_A,
    PREF_B
  } arb_state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter with a pointer FSM.
//   clk_i, reset_i   : clock, synchronous active-high reset
//   req_a_i, req_b_i : requests
//   force_b_i        : when both request, grant B without moving the pointer
//   gnt_a_o, gnt_b_o : one-hot-or-zero grants (zero while reset is high)
module rr_arb2
  import rf_pkg::*;
(
  input  logic clk_i,
  input  logic reset_i,
  input  logic req_a_i,
  input  logic req_b_i,
  input  logic force_b_i,
  output logic gnt_a_o,
  output logic gnt_b_o
);

  arb_state_e state_q, state_d;
  logic       contended;

  assign contended = req_a_i & req_b_i;

  // State register
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= PREF_A;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: the pointer only moves when a contended cycle is settled by round-robin
  always_comb begin
    state_d = state_q;
    if (contended && !force_b_i) begin
      unique case (state_q)
        PREF_A:  state_d = PREF_B;
        PREF_B:  state_d = PREF_A;
        default: state_d = PREF_A;
      endcase
    end
  end

  // Grant outputs
  always_comb begin
    gnt_a_o = 1'b0;
    gnt_b_o = 1'b0;
    if (!reset_i) begin
      if (contended) begin
        if (force_b_i || state_q == PREF_B) begin
          gnt_b_o = 1'b1;
        end else begin
          gnt_a_o = 1'b1;
        end
      end else begin
        gnt_a_o = req_a_i;
        gnt_b_o = req_b_i;
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register file's single write port between the ALU result path (A) and the
// load-return path (B). Accepted writes are registered and drive the register file for one cycle.
//   clk, reset                  : clock, synchronous active-high reset
//   a_valid/a_rd/a_data/a_ready : requester A handshake
//   b_valid/b_rd/b_data/b_ready : requester B handshake
//   rf_rd/rf_writedata/rf_reg_write : register file write port
//   pending_mask                : destinations waiting or in the output stage (bit 0 always 0)
//   conflict_cnt                : saturating count of cycles with both requesters valid
module regfile_wb_arbiter
  import rf_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             a_valid,
  input  logic [AW-1:0]    a_rd,
  input  logic [XLEN-1:0]  a_data,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [AW-1:0]    b_rd,
  input  logic [XLEN-1:0]  b_data,
  output logic             b_ready,
  output logic [AW-1:0]    rf_rd,
  output logic [XLEN-1:0]  rf_writedata,
  output logic             rf_reg_write,
  output logic [NREG-1:0]  pending_mask,
  output logic [CNT_W-1:0] conflict_cnt
);

  logic       force_b;
  rf_wreq_t   acc;
  rf_wreq_t   wreq_q, wreq_d;
  logic       we_q, we_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Same nonzero destination: B is the older instruction, so it goes first and A's value lands last
  assign force_b = a_valid & b_valid & (a_rd == b_rd) & (a_rd != '0);

  rr_arb2 u_arb (
    .clk_i     (clk),
    .reset_i   (reset),
    .req_a_i   (a_valid),
    .req_b_i   (b_valid),
    .force_b_i (force_b),
    .gnt_a_o   (a_ready),
    .gnt_b_o   (b_ready)
  );

  // Output stage next state; writes to x0 are accepted but never reach the register file
  always_comb begin
    acc.rd   = b_rd;
    acc.data = b_data;
    if (a_ready) begin
      acc.rd   = a_rd;
      acc.data = a_data;
    end
    we_d   = (a_ready | b_ready) & (acc.rd != '0);
    wreq_d = we_d ? acc : '0;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (a_valid && b_valid && cnt_q != '1) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      we_q   <= 1'b0;
      wreq_q <= '0;
      cnt_q  <= '0;
    end else begin
      we_q   <= we_d;
      wreq_q <= wreq_d;
      cnt_q  <= cnt_d;
    end
  end

  assign rf_reg_write = we_q;
  assign rf_rd        = wreq_q.rd;
  assign rf_writedata = wreq_q.data;
  assign conflict_cnt = cnt_q;

  always_comb begin
    pending_mask = '0;
    if (a_valid && !a_ready) pending_mask[a_rd] = 1'b1;
    if (b_valid && !b_ready) pending_mask[b_rd] = 1'b1;
    if (we_q)                pending_mask[wreq_q.rd] = 1'b1;
    pending_mask[0] = 1'b0;
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;
  import rf_pkg::*;

  localparam int unsigned CNT_W = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             a_valid, b_valid, a_ready, b_ready;
  logic [AW-1:0]    a_rd, b_rd, rf_rd;
  logic [XLEN-1:0]  a_data, b_data, rf_writedata;
  logic             rf_reg_write;
  logic [NREG-1:0]  pending_mask;
  logic [CNT_W-1:0] conflict_cnt;

  int n_checks = 0;
  int n_errors = 0;

  rf_wreq_t        exp_q[$];
  logic [XLEN-1:0] rf_model [NREG];
  logic            ptr_a; // bench's own round-robin pointer: 1 = A preferred

  regfile_wb_arbiter #(.CNT_W(CNT_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .a_valid      (a_valid),
    .a_rd         (a_rd),
    .a_data       (a_data),
    .a_ready      (a_ready),
    .b_valid      (b_valid),
    .b_rd         (b_rd),
    .b_data       (b_data),
    .b_ready      (b_ready),
    .rf_rd        (rf_rd),
    .rf_writedata (rf_writedata),
    .rf_reg_write (rf_reg_write),
    .pending_mask (pending_mask),
    .conflict_cnt (conflict_cnt)
  );

  always #5 clk = ~clk;

  // Register file model commits on negedge; every write it sees is checked against the scoreboard
  always @(negedge clk) begin
    if (rf_reg_write === 1'b1) begin
      rf_wreq_t exp;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL sb_unexpected_write: got rd=%0d data=%h, required no write",
                 rf_rd, rf_writedata);
      end else begin
        exp = exp_q.pop_front();
        if (rf_rd !== exp.rd || rf_writedata !== exp.data) begin
          n_errors++;
          $display("FAIL sb_write: got rd=%0d data=%h, required rd=%0d data=%h",
                   rf_rd, rf_writedata, exp.rd, exp.data);
        end
      end
      rf_model[rf_rd] = rf_writedata;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    a_valid = 1'b0; a_rd = '0; a_data = '0;
    b_valid = 1'b0; b_rd = '0; b_data = '0;
  endtask

  task automatic push(input logic [AW-1:0] rd, input logic [XLEN-1:0] data);
    rf_wreq_t w;
    w.rd = rd;
    w.data = data;
    if (rd != '0) exp_q.push_back(w);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    a_valid = 1'b1; a_rd = 5; a_data = 64'h55;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if (a_ready !== 1'b0) begin n_errors++; $display("FAIL reset_a_ready: got %b required 0", a_ready); end
      n_checks++;
      if (rf_reg_write !== 1'b0) begin n_errors++; $display("FAIL reset_reg_write: got %b required 0", rf_reg_write); end
      n_checks++;
      if (conflict_cnt !== '0) begin n_errors++; $display("FAIL reset_cnt: got %0d required 0", conflict_cnt); end
    end
    reset = 1'b0;
    idle_inputs();
    ptr_a = 1'b1;
  endtask

  task automatic test_single();
    a_valid = 1'b1; a_rd = 3; a_data = 64'h1234;
    #1;
    n_checks++;
    if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
      n_errors++; $display("FAIL single_ready: got a=%b b=%b required a=1 b=0", a_ready, b_ready);
    end
    push(3, 64'h1234);
    step();
    idle_inputs();
    n_checks++;
    if (rf_reg_write !== 1'b1 || rf_rd !== 3 || rf_writedata !== 64'h1234) begin
      n_errors++;
      $display("FAIL single_out: got we=%b rd=%0d data=%h required we=1 rd=3 data=1234",
               rf_reg_write, rf_rd, rf_writedata);
    end
    n_checks++;
    if (pending_mask !== (NREG'(1) << 3)) begin
      n_errors++; $display("FAIL single_pending: got %h required %h", pending_mask, NREG'(1) << 3);
    end
    step();
    n_checks++;
    if (rf_reg_write !== 1'b0) begin n_errors++; $display("FAIL single_one_cycle: got %b required 0", rf_reg_write); end
  endtask

  task automatic test_round_robin();
    for (int k = 0; k < 4; k++) begin
      a_valid = 1'b1; a_rd = 1; a_data = 64'h100 + XLEN'(k);
      b_valid = 1'b1; b_rd = 2; b_data = 64'h200 + XLEN'(k);
      #1;
      n_checks++;
      if (a_ready !== ptr_a || b_ready !== !ptr_a) begin
        n_errors++;
        $display("FAIL rr_grant%0d: got a=%b b=%b required a=%b b=%b", k, a_ready, b_ready, ptr_a, !ptr_a);
      end
      if (k == 0) begin
        n_checks++;
        if (pending_mask !== (NREG'(1) << 2)) begin
          n_errors++; $display("FAIL rr_pending: got %h required %h", pending_mask, NREG'(1) << 2);
        end
      end
      if (ptr_a) push(1, a_data); else push(2, b_data);
      ptr_a = !ptr_a;
      step();
    end
    idle_inputs();
    n_checks++;
    if (conflict_cnt !== 16'd4) begin n_errors++; $display("FAIL rr_cnt: got %0d required 4", conflict_cnt); end
    step();
  endtask

  task automatic test_same_rd();
    a_valid = 1'b1; a_rd = 7; a_data = 64'hAA;
    b_valid = 1'b1; b_rd = 7; b_data = 64'hBB;
    #1;
    n_checks++;
    if (a_ready !== 1'b0 || b_ready !== 1'b1) begin
      n_errors++; $display("FAIL same_rd_first: got a=%b b=%b required a=0 b=1", a_ready, b_ready);
    end
    n_checks++;
    if (pending_mask !== (NREG'(1) << 7)) begin
      n_errors++; $display("FAIL same_rd_pending: got %h required %h", pending_mask, NREG'(1) << 7);
    end
    push(7, 64'hBB);
    step();
    b_valid = 1'b0;
    #1;
    n_checks++;
    if (a_ready !== 1'b1) begin n_errors++; $display("FAIL same_rd_second: got a=%b required 1", a_ready); end
    push(7, 64'hAA);
    step();
    // Pointer must not have moved: contended distinct rds still go to A
    a_valid = 1'b1; a_rd = 1; a_data = 64'h11;
    b_valid = 1'b1; b_rd = 2; b_data = 64'h22;
    #1;
    n_checks++;
    if (a_ready !== ptr_a || b_ready !== !ptr_a) begin
      n_errors++; $display("FAIL same_rd_ptr: got a=%b b=%b required a=%b b=%b", a_ready, b_ready, ptr_a, !ptr_a);
    end
    if (ptr_a) push(1, a_data); else push(2, b_data);
    ptr_a = !ptr_a;
    step();
    idle_inputs();
    n_checks++;
    if (conflict_cnt !== 16'd6) begin n_errors++; $display("FAIL same_rd_cnt: got %0d required 6", conflict_cnt); end
    step();
    step();
    n_checks++;
    if (rf_model[7] !== 64'hAA) begin n_errors++; $display("FAIL same_rd_final: got %h required aa", rf_model[7]); end
  endtask

  task automatic test_x0();
    b_valid = 1'b1; b_rd = 0; b_data = 64'hFF;
    #1;
    n_checks++;
    if (b_ready !== 1'b1) begin n_errors++; $display("FAIL x0_ready: got %b required 1", b_ready); end
    n_checks++;
    if (pending_mask !== '0) begin n_errors++; $display("FAIL x0_pending: got %h required 0", pending_mask); end
    step();
    idle_inputs();
    n_checks++;
    if (rf_reg_write !== 1'b0 || rf_rd !== '0 || rf_writedata !== '0) begin
      n_errors++;
      $display("FAIL x0_out: got we=%b rd=%0d data=%h required all zero", rf_reg_write, rf_rd, rf_writedata);
    end
  endtask

  task automatic test_reset_mid();
    a_valid = 1'b1; a_rd = 4; a_data = 64'h4444;
    #1;
    n_checks++;
    if (a_ready !== 1'b1) begin n_errors++; $display("FAIL rstmid_ready: got %b required 1", a_ready); end
    reset = 1'b1;
    #1;
    n_checks++;
    if (a_ready !== 1'b0) begin n_errors++; $display("FAIL rstmid_blocked: got %b required 0", a_ready); end
    step();
    n_checks++;
    if (rf_reg_write !== 1'b0) begin n_errors++; $display("FAIL rstmid_we: got %b required 0", rf_reg_write); end
    n_checks++;
    if (conflict_cnt !== '0) begin n_errors++; $display("FAIL rstmid_cnt: got %0d required 0", conflict_cnt); end
    reset = 1'b0;
    idle_inputs();
    ptr_a = 1'b1;
    step();
    n_checks++;
    if (rf_model[4] !== '0) begin n_errors++; $display("FAIL rstmid_reg4: got %h required 0", rf_model[4]); end
  endtask

  task automatic test_saturation();
    // Both target x0 so the long run produces no register writes
    a_valid = 1'b1; a_rd = 0; a_data = '0;
    b_valid = 1'b1; b_rd = 0; b_data = '0;
    repeat (65534) @(posedge clk);
    #1;
    n_checks++;
    if (conflict_cnt !== 16'hFFFE) begin n_errors++; $display("FAIL sat_pre: got %h required fffe", conflict_cnt); end
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if (conflict_cnt !== 16'hFFFF) begin n_errors++; $display("FAIL sat_hold%0d: got %h required ffff", i, conflict_cnt); end
    end
    idle_inputs();
    step();
    n_checks++;
    if (conflict_cnt !== 16'hFFFF) begin n_errors++; $display("FAIL sat_idle: got %h required ffff", conflict_cnt); end
  endtask

  initial begin
    for (int i = 0; i < int'(NREG); i++) rf_model[i] = '0;
    idle_inputs();
    reset = 1'b1;
    ptr_a = 1'b1;
    test_reset();
    test_single();
    test_round_robin();
    test_same_rd();
    test_x0();
    test_reset_mid();
    test_saturation();
    step();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++; $display("FAIL sb_leftover: got %0d outstanding writes required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
